// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 1 Hz prescaler driving a 24-hour BCD HH:MM:SS count with set pulses and display mux
module bcd_time_counter #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        inc_min,
  input  logic        inc_hr,
  input  logic        disp_sel,
  output logic [15:0] bcd,
  output logic        sec_tick,
  output logic        colon
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] HALF = PW'(TICKS_PER_SEC / 2);
  logic [PW-1:0] prescaler;
  logic [3:0] s_lo, s_hi, m_lo, m_hi, h_lo, h_hi;
  logic [3:0] s_lo_n, s_hi_n, m_lo_n, m_hi_n, h_lo_n, h_hi_n;
  logic tick, inc, sec_step, sec_wrap, min_wrap, min_step, hr_step, day_wrap;
  always_comb begin
    tick = run && prescaler == LAST;
    inc = inc_min | inc_hr;
    // a set pulse swallows a coincident tick entirely
    sec_step = tick & ~inc;
    sec_wrap = s_hi == 4'd5 && s_lo == 4'd9;
    min_wrap = m_hi == 4'd5 && m_lo == 4'd9;
    day_wrap = h_hi == 4'd2 && h_lo == 4'd3;
    min_step = inc_min | (sec_step & sec_wrap);
    hr_step = inc_hr | (sec_step & sec_wrap & min_wrap);
    s_lo_n = inc_min ? 4'd0 : sec_step ? (s_lo == 4'd9 ? 4'd0 : s_lo + 4'd1) : s_lo;
    s_hi_n = inc_min ? 4'd0 : (sec_step && s_lo == 4'd9) ? (s_hi == 4'd5 ? 4'd0 : s_hi + 4'd1) : s_hi;
    m_lo_n = min_step ? (m_lo == 4'd9 ? 4'd0 : m_lo + 4'd1) : m_lo;
    m_hi_n = (min_step && m_lo == 4'd9) ? (m_hi == 4'd5 ? 4'd0 : m_hi + 4'd1) : m_hi;
    h_lo_n = hr_step ? ((h_lo == 4'd9 || day_wrap) ? 4'd0 : h_lo + 4'd1) : h_lo;
    h_hi_n = hr_step ? (day_wrap ? 4'd0 : h_lo == 4'd9 ? h_hi + 4'd1 : h_hi) : h_hi;
    bcd = disp_sel ? {m_hi, m_lo, s_hi, s_lo} : {h_hi, h_lo, m_hi, m_lo};
    colon = ~run | (prescaler < HALF);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      sec_tick <= 1'b0;
      {s_lo, s_hi, m_lo, m_hi, h_lo, h_hi} <= '0;
    end else begin
      prescaler <= (!run || tick) ? '0 : prescaler + 1'b1;
      sec_tick <= sec_step;
      {s_lo, s_hi, m_lo, m_hi, h_lo, h_hi} <= {s_lo_n, s_hi_n, m_lo_n, m_hi_n, h_lo_n, h_hi_n};
    end
  end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed and random stimulus against a seconds-of-day reference model
module tb_bcd_time_counter;
  localparam int T = 4;
  logic clk = 1'b0, reset, run, inc_min, inc_hr, disp_sel;
  logic [15:0] bcd;
  logic sec_tick, colon;
  int n_checks = 0, n_pass = 0;
  int t = 0, ph = 0;
  bit m_st = 0;

  bcd_time_counter #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .run(run), .inc_min(inc_min), .inc_hr(inc_hr),
    .disp_sel(disp_sel), .bcd(bcd), .sec_tick(sec_tick), .colon(colon)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [15:0] exp_bcd(input logic sel);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return sel ? 16'((m / 10) * 4096 + (m % 10) * 256 + (s / 10) * 16 + s % 10)
               : 16'((h / 10) * 4096 + (h % 10) * 256 + (m / 10) * 16 + m % 10);
  endfunction

  task automatic model_update();
    int h, m, s;
    bit tk;
    if (reset) begin
      t = 0; ph = 0; m_st = 0;
    end else begin
      tk = run && ph == T - 1;
      ph = run ? (ph + 1) % T : 0;
      if (inc_min || inc_hr) begin
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        if (inc_min) begin m = (m + 1) % 60; s = 0; end
        if (inc_hr) h = (h + 1) % 24;
        t = h * 3600 + m * 60 + s;
        m_st = 0;
      end else begin
        m_st = tk;
        if (tk) t = (t + 1) % 86400;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("bcd", bcd, exp_bcd(disp_sel));
    check("colon", {15'd0, colon}, {15'd0, !run || ph < T / 2});
    check("sec_tick", {15'd0, sec_tick}, {15'd0, m_st});
    disp_sel = ~disp_sel;
    #1;
    check("bcd_alt", bcd, exp_bcd(disp_sel));
    disp_sel = ~disp_sel;
    #1;
  endtask

  task automatic pulse(input bit mn, input bit hr);
    inc_min = mn; inc_hr = hr;
    step();
    inc_min = 0; inc_hr = 0;
  endtask

  task automatic go_to(input int h, input int m, input int s);
    reset = 1; run = 0;
    step();
    reset = 0;
    repeat (h) pulse(1'b0, 1'b1);
    repeat (m) pulse(1'b1, 1'b0);
    run = 1;
    repeat (s * T) step();
  endtask

  initial begin
    reset = 1; run = 1; inc_min = 0; inc_hr = 0; disp_sel = 1;
    #1;
    step(); step();
    check("reset_bcd", bcd, 16'h0000);
    check("reset_colon", {15'd0, colon}, 16'd1);
    reset = 0;
    for (int k = 1; k <= 3; k++) begin
      repeat (T) step();
      check("s1_tick", {15'd0, sec_tick}, 16'd1);
      check("s1_bcd", bcd, 16'(k));
    end
    step();
    check("s1_tick_gone", {15'd0, sec_tick}, 16'd0);
    // minute carry into the tens of minutes
    go_to(0, 9, 59);
    run = 1;
    repeat (T) step();
    check("s2_mmss", bcd, 16'h1000);
    disp_sel = 0; #1;
    check("s2_hhmm", bcd, 16'h0010);
    // day wrap from 23:59:59
    go_to(23, 59, 59);
    repeat (T) step();
    check("s3_hhmm", bcd, 16'h0000);
    disp_sel = 1; #1;
    check("s3_mmss", bcd, 16'h0000);
    // set-pulse wraps while paused
    go_to(0, 59, 0);
    run = 0; disp_sel = 0;
    pulse(1'b1, 1'b0);
    check("s4_min_wrap", bcd, 16'h0000);
    go_to(23, 7, 0);
    run = 0;
    pulse(1'b0, 1'b1);
    check("s4_hr_wrap", bcd, 16'h0007);
    go_to(12, 34, 56);
    run = 0;
    pulse(1'b1, 1'b0);
    check("s4_hhmm", bcd, 16'h1235);
    disp_sel = 1; #1;
    check("s4_mmss", bcd, 16'h3500);
    // inc_min lands on the tick edge
    go_to(0, 10, 30);
    repeat (T - 1) step();
    pulse(1'b1, 1'b0);
    check("s5_tick_drop", {15'd0, sec_tick}, 16'd0);
    check("s5_mmss", bcd, 16'h1100);
    go_to(5, 7, 0);
    run = 0; disp_sel = 0;
    pulse(1'b1, 1'b1);
    check("s5_both", bcd, 16'h0608);
    // reset mid-second
    go_to(3, 21, 17);
    step(); step();
    reset = 1;
    step();
    check("s6_bcd", bcd, 16'h0000);
    check("s6_tick", {15'd0, sec_tick}, 16'd0);
    reset = 0;
    repeat (T - 1) step();
    check("s6_no_tick_yet", {15'd0, sec_tick}, 16'd0);
    step();
    check("s6_first_tick", {15'd0, sec_tick}, 16'd1);
    // random traffic, with pulses biased onto tick edges now and then
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 39) == 0) run = ~run;
      inc_min = $urandom_range(0, 19) == 0 || (ph == T - 1 && $urandom_range(0, 3) == 0);
      inc_hr = $urandom_range(0, 29) == 0;
      disp_sel = 1'($urandom_range(0, 1));
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Timekeeping core of the digital clock; sits directly upstream of the 4-digit multiplexed 7-segment display driver and supplies its 16-bit packed-BCD input. It divides the system clock to a 1 Hz tick and maintains a 24-hour HH:MM:SS count in BCD. It also provides manual set pulses for hours and minutes, and selects which pair of fields (HH:MM or MM:SS) is presented to the display. A colon/blink signal is provided for the display's decimal-point driver.

## Interface
- TICKS_PER_SEC, 100_000_000, clk cycles per second; must be at least 2.
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = time advances on each tick; 0 = paused (set mode).
- inc_min  in  1  single-cycle pulse, already debounced; minute +1.
- inc_hr  in  1  single-cycle pulse, already debounced; hour +1.
- disp_sel  in  1  0 = show HH:MM; 1 = show MM:SS.
- bcd  out  16  packed BCD, bcd[15:12] = most significant digit, bcd[3:0] = least.
- sec_tick  out  1  one-cycle pulse in the cycle a new second value first appears.
- colon  out  1  blink for the display DP/colon: 1 = lit.

## Operation
- Registers:
  - prescaler 0..TICKS_PER_SEC-1, width $clog2(TICKS_PER_SEC).
  - Six BCD digits: s_lo 0-9, s_hi 0-5, m_lo 0-9, m_hi 0-5, h_lo 0-9, h_hi 0-2.
- Reset: prescaler=0, all digits 0, sec_tick=0. Outputs after reset: bcd=16'h0000, colon=1.
- Prescaler:
  - With run=1, it counts up and wraps from TICKS_PER_SEC-1 to 0; the wrap constitutes a tick.
  - With run=0, it is held at 0 and no ticks occur.
- Tick carry chain: s_lo 9→0 carries into s_hi; s_hi 5→0 carries into m_lo; m_lo 9→0 carries into m_hi; m_hi 5→0 carries into hours.
- Hours: h_lo increments 0-9. h_lo=9 → 0 with h_hi +1. Hours 23 → 00, clearing both h_hi and h_lo. No 12-hour mode.
- inc_min: minutes +1 modulo 60 with no carry into hours; seconds are cleared to 00.
- inc_hr: hours +1 modulo 24; minutes and seconds are unchanged.
- inc_min and inc_hr are honoured regardless of run.
- Simultaneous events:
  - inc_min and inc_hr in the same cycle: both apply (seconds cleared, minutes +1, hours +1).
  - Any inc pulse in the same cycle as a tick: the tick is discarded. The time does not advance from the tick, and sec_tick stays 0. The prescaler still wraps to 0.
- bcd is a combinational mux of the digit registers:
  - disp_sel=0: {h_hi,h_lo,m_hi,m_lo}.
  - disp_sel=1: {m_hi,m_lo,s_hi,s_lo}.
- colon:
  - With run=1: 1 while prescaler < TICKS_PER_SEC/2 (integer division), else 0.
  - With run=0: steady 1.
- Illegal digit codes are unreachable from reset; no recovery logic is required.

## Timing
- Tick period: exactly TICKS_PER_SEC cycles while run stays 1.
  - The first tick occurs TICKS_PER_SEC cycles after reset deasserts with run=1. Equivalently, it occurs TICKS_PER_SEC cycles after run rises from 0.
- Tick edge: the edge that takes the prescaler from TICKS_PER_SEC-1 to 0 also updates the digits and sets the registered sec_tick=1 for exactly one cycle. New digits and sec_tick are therefore coincident.
- Manual increments: an inc pulse sampled at edge N gives updated digits after edge N (one-cycle latency).
- disp_sel: a change affects bcd in the same cycle (combinational, zero latency).
- run falling mid-count: at the next edge the prescaler returns to 0 and the partial second is discarded.
- Reset asserted mid-operation, including on a tick cycle: reset has priority over everything. All registers take reset values at that edge; sec_tick=0 in the following cycle.

## Test plan
All scenarios use TICKS_PER_SEC=4.
1. Reset, then run=1 with disp_sel=1.
   - bcd=16'h0000 and colon=1 during and after reset.
   - sec_tick pulses on cycles 4, 8, 12 after reset release; bcd reads 16'h0001, 16'h0002, 16'h0003.
   - colon pattern per second is 1,1,0,0.
2. Minute carry: set 00:09:59 with run=0, then run=1.
   - At the next tick, disp_sel=1 shows 16'h1000 and disp_sel=0 shows 16'h0010.
3. Day wrap: pulse inc_hr 23 times and inc_min 59 times, then run 59 ticks to reach 23:59:59.
   - The next tick gives 00:00:00: bcd=16'h0000 for both disp_sel values.
4. Set-pulse wraps with run=0:
   - At 00:59, inc_min → 00:00; hours unchanged.
   - At 23:xx, inc_hr → 00:xx.
   - With time 12:34:56, inc_min → 12:35:00.
5. Coincident events:
   - inc_min on the tick cycle at 00:10:30 → 00:11:00 and sec_tick=0.
   - inc_min and inc_hr together at 05:07 → 06:08.
6. Reset mid-run at 03:21:17 with prescaler=2.
   - All digits are 0 and sec_tick=0 the next cycle.
   - The first sec_tick follows 4 cycles after reset release.
